riscv_vector_register_file_ff_be: RTL and testbench
===================================================

// Module: riscv_vector_register_file_ff_be
// PURPOSE
//  Flip-flop vector/crypto register file for the RISC-V crypto extension: 2**VADDR_WIDTH regs of
//  VDATA_WIDTH bits, 3 async read ports, 2 byte-masked write ports, optional write->read bypass.
//  Adds per-register busy scoreboard (reserve/release handshake) so the ID stage can stall on
//  multi-cycle crypto ops (AES rounds, SHA blocks). Sits beside the scalar RF in the ID stage.
// PARAMETERS
//  VADDR_WIDTH  5    register address width; NREGS = 2**VADDR_WIDTH
//  VDATA_WIDTH  256  register width in bits; must be a multiple of 8
//  ZERO_REG     1    1: v0 hard-wired to zero, writes/reserves of v0 ignored
//  BYPASS       1    1: read ports return same-cycle write data for matching address
// PORTS
//  clk           in   1            clock, all state updates on rising edge
//  rst           in   1            synchronous active-high reset
//  vraddr_{a,b,c}_i in VADDR_WIDTH read addresses
//  vrdata_{a,b,c}_o out VDATA_WIDTH read data (combinational)
//  vbusy_{a,b,c}_o  out 1          busy bit of register addressed by the read port
//  vwaddr_{a,b}_i   in  VADDR_WIDTH write addresses
//  vwdata_{a,b}_i   in  VDATA_WIDTH write data
//  vwbe_{a,b}_i     in  VDATA_WIDTH/8 byte enables (bit n -> bits 8n+7:8n)
//  vwe_{a,b}_i      in  1          write enables
//  vwrel_{a,b}_i    in  1          with vwe: clear busy bit of vwaddr (final write of an op)
//  vres_valid_i     in  1          reserve request
//  vres_addr_i      in  VADDR_WIDTH register to reserve
//  vres_ready_o     out 1          reserve accepted this cycle
//  vrel_err_o       out 1          registered 1-cycle pulse: release hit a non-busy register
// BEHAVIOUR
//  Reset (rst=1 at edge): all regs <= 0, all busy <= 0, vrel_err_o <= 0. Consequently after reset
//   all vrdata = 0, vbusy = 0, vres_ready_o = 1. rst mid-op aborts all reservations; no write
//   that cycle takes effect.
//  Write: at edge, for each port with vwe=1, bytes with be=1 update reg[vwaddr]; others hold.
//   vwe with be=0 is legal: no data change, release still applies. Latency 1 cycle to array.
//  Collision: both ports same addr -> per byte, B wins where both enabled; union otherwise.
//  ZERO_REG=1: reg[0] reads 0 always; writes/release/reserve to 0 are dropped (no error pulse),
//   vres_ready_o=1 for addr 0, busy[0] stays 0.
//  Read: vrdata_x = reg[vraddr_x]. BYPASS=1: per byte, if a write port targets vraddr_x with that
//   byte enabled this cycle, return its data (B over A); else array. BYPASS=0: array only,
//   written data visible the cycle after the edge. Addr 0 with ZERO_REG never bypassed.
//  Scoreboard: vres_ready_o = ~busy[vres_addr_i] (no forwarding of same-cycle release; a
//   busy register is reservable the cycle after its release). valid&ready -> busy<=1.
//  Release: vwe&vwrel on port p -> busy[vwaddr_p]<=0. Both ports releasing same reg: one clear.
//   Release of non-busy reg (ZERO_REG aside) -> vrel_err_o=1 next cycle, no other effect.
//  Same-cycle reserve of reg X and release of reg Y!=X: both applied. Reserve of X while X
//   released: impossible (ready=0), release applies.
//  vbusy_x_o = busy[vraddr_x] of current state (not bypassed by same-cycle release/reserve).
//  Writes to busy or non-busy regs are both legal; busy gates only the handshake/stall.
// TESTING
//  1 Reset, then read all 32 regs on ports a/b/c -> all 0, vbusy=0, vres_ready_o=1.
//  2 Write A addr 5 data 'hAA.. be all-ones; same cycle B addr 5 data 'h55.. be=lower half ->
//    next cycle reg5 = upper half 'hAA.., lower half 'h55..; with BYPASS=1 read same cycle shows same.
//  3 Reserve v7 -> ready=1, next cycle vbusy=1 and a second reserve of v7 sees ready=0; write
//    port A v7 with vwrel=1 -> next cycle busy=0, ready=1, vrel_err_o=0.
//  4 Release v9 never reserved -> vrel_err_o pulses 1 exactly one cycle later, reg9 data updated.
//  5 ZERO_REG=1: write v0 'hFF.. and reserve v0 -> v0 still reads 0, vbusy=0, no error.
//  6 Reserve v3, write v3 data 'h12.., assert rst -> next cycle reg3=0, busy3=0, vrel_err_o=0.

Source files
------------

// File: rtl/riscv_vector_register_file_ff_be.sv
// Flip-flop vector/crypto register file with byte-masked writes, optional
// write->read bypass and a per-register busy scoreboard. The ID stage uses
// the scoreboard to stall on multi-cycle crypto operations.
module riscv_vector_register_file_ff_be #(
    parameter int VADDR_WIDTH = 5,
    parameter int VDATA_WIDTH = 256,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [VADDR_WIDTH-1:0]     vraddr_a_i,
    input  logic [VADDR_WIDTH-1:0]     vraddr_b_i,
    input  logic [VADDR_WIDTH-1:0]     vraddr_c_i,
    output logic [VDATA_WIDTH-1:0]     vrdata_a_o,
    output logic [VDATA_WIDTH-1:0]     vrdata_b_o,
    output logic [VDATA_WIDTH-1:0]     vrdata_c_o,
    output logic                       vbusy_a_o,
    output logic                       vbusy_b_o,
    output logic                       vbusy_c_o,
    input  logic [VADDR_WIDTH-1:0]     vwaddr_a_i,
    input  logic [VADDR_WIDTH-1:0]     vwaddr_b_i,
    input  logic [VDATA_WIDTH-1:0]     vwdata_a_i,
    input  logic [VDATA_WIDTH-1:0]     vwdata_b_i,
    input  logic [VDATA_WIDTH/8-1:0]   vwbe_a_i,
    input  logic [VDATA_WIDTH/8-1:0]   vwbe_b_i,
    input  logic                       vwe_a_i,
    input  logic                       vwe_b_i,
    input  logic                       vwrel_a_i,
    input  logic                       vwrel_b_i,
    input  logic                       vres_valid_i,
    input  logic [VADDR_WIDTH-1:0]     vres_addr_i,
    output logic                       vres_ready_o,
    output logic                       vrel_err_o
);

    localparam int NREGS  = 2 ** VADDR_WIDTH;
    localparam int NBYTES = VDATA_WIDTH / 8;

    logic [VDATA_WIDTH-1:0] regs_q [NREGS];
    logic [VDATA_WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0]       busy_q;
    logic [NREGS-1:0]       busy_d;
    logic                   rel_err_q;
    logic                   rel_err_d;

    // Replace the enabled bytes of old_v with those of new_v.
    function automatic logic [VDATA_WIDTH-1:0] merge_bytes(
        input logic [VDATA_WIDTH-1:0] old_v,
        input logic [VDATA_WIDTH-1:0] new_v,
        input logic [NBYTES-1:0]      be
    );
        logic [VDATA_WIDTH-1:0] res;
        res = old_v;
        for (int n = 0; n < NBYTES; n++) begin
            if (be[n]) begin
                res[8*n +: 8] = new_v[8*n +: 8];
            end
        end
        return res;
    endfunction

    // Writes, releases and reserves aimed at a hard-wired v0 are dropped here,
    // so v0 never changes, never becomes busy and never raises a release error.
    logic zero_wa, zero_wb, zero_res;
    logic we_a_eff, we_b_eff, rel_a_eff, rel_b_eff, res_eff;

    assign zero_wa   = (ZERO_REG != 0) && (vwaddr_a_i == '0);
    assign zero_wb   = (ZERO_REG != 0) && (vwaddr_b_i == '0);
    assign zero_res  = (ZERO_REG != 0) && (vres_addr_i == '0);
    assign we_a_eff  = vwe_a_i && !zero_wa;
    assign we_b_eff  = vwe_b_i && !zero_wb;
    assign rel_a_eff = we_a_eff && vwrel_a_i;
    assign rel_b_eff = we_b_eff && vwrel_b_i;

    // No forwarding of a same-cycle release: a register becomes reservable
    // only the cycle after its busy bit clears.
    assign vres_ready_o = ~busy_q[vres_addr_i];
    assign res_eff      = vres_valid_i && vres_ready_o && !zero_res;

    // Next array contents: port A applied first so port B wins overlapping bytes.
    always_comb begin
        regs_d = regs_q;
        if (we_a_eff) begin
            regs_d[vwaddr_a_i] = merge_bytes(regs_q[vwaddr_a_i], vwdata_a_i, vwbe_a_i);
        end
        if (we_b_eff) begin
            regs_d[vwaddr_b_i] = merge_bytes(regs_d[vwaddr_b_i], vwdata_b_i, vwbe_b_i);
        end
    end

    // Scoreboard next state: releases clear, an accepted reserve sets, and a
    // release of a register that is not busy flags an error for one cycle.
    always_comb begin
        busy_d    = busy_q;
        rel_err_d = 1'b0;
        if (rel_a_eff) begin
            busy_d[vwaddr_a_i] = 1'b0;
            if (!busy_q[vwaddr_a_i]) begin
                rel_err_d = 1'b1;
            end
        end
        if (rel_b_eff) begin
            busy_d[vwaddr_b_i] = 1'b0;
            if (!busy_q[vwaddr_b_i]) begin
                rel_err_d = 1'b1;
            end
        end
        if (res_eff) begin
            busy_d[vres_addr_i] = 1'b1;
        end
    end

    // State registers; reset clears data, reservations and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q    <= '0;
            rel_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q    <= busy_d;
            rel_err_q <= rel_err_d;
        end
    end

    assign vrel_err_o = rel_err_q;

    logic [VADDR_WIDTH-1:0] rd_addr [3];
    assign rd_addr[0] = vraddr_a_i;
    assign rd_addr[1] = vraddr_b_i;
    assign rd_addr[2] = vraddr_c_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            logic [VDATA_WIDTH-1:0] data;
            logic                   busy;

            // Array read, optionally overlaid per byte with same-cycle write data (B over A).
            always_comb begin
                data = regs_q[rd_addr[gi]];
                if (BYPASS != 0) begin
                    if (we_a_eff && (vwaddr_a_i == rd_addr[gi])) begin
                        data = merge_bytes(data, vwdata_a_i, vwbe_a_i);
                    end
                    if (we_b_eff && (vwaddr_b_i == rd_addr[gi])) begin
                        data = merge_bytes(data, vwdata_b_i, vwbe_b_i);
                    end
                end
                if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                    data = '0;
                end
            end

            assign busy = busy_q[rd_addr[gi]];
        end
    endgenerate

    assign vrdata_a_o = g_rd[0].data;
    assign vrdata_b_o = g_rd[1].data;
    assign vrdata_c_o = g_rd[2].data;
    assign vbusy_a_o  = g_rd[0].busy;
    assign vbusy_b_o  = g_rd[1].busy;
    assign vbusy_c_o  = g_rd[2].busy;

endmodule

// File: tb/tb_riscv_vector_register_file_ff_be.sv
// Bench for the vector register file: directed scenarios followed by random
// traffic, all compared against a byte-level behavioural model.
module tb_riscv_vector_register_file_ff_be;

    localparam int AW = 5;
    localparam int DW = 256;
    localparam int NB = DW / 8;
    localparam int NR = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] vraddr_a_i, vraddr_b_i, vraddr_c_i;
    logic [DW-1:0] vrdata_a_o, vrdata_b_o, vrdata_c_o;
    logic          vbusy_a_o, vbusy_b_o, vbusy_c_o;
    logic [AW-1:0] vwaddr_a_i, vwaddr_b_i;
    logic [DW-1:0] vwdata_a_i, vwdata_b_i;
    logic [NB-1:0] vwbe_a_i, vwbe_b_i;
    logic          vwe_a_i, vwe_b_i, vwrel_a_i, vwrel_b_i;
    logic          vres_valid_i;
    logic [AW-1:0] vres_addr_i;
    logic          vres_ready_o;
    logic          vrel_err_o;

    always #5 clk = ~clk;

    riscv_vector_register_file_ff_be #(
        .VADDR_WIDTH(AW), .VDATA_WIDTH(DW), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .vraddr_a_i(vraddr_a_i), .vraddr_b_i(vraddr_b_i), .vraddr_c_i(vraddr_c_i),
        .vrdata_a_o(vrdata_a_o), .vrdata_b_o(vrdata_b_o), .vrdata_c_o(vrdata_c_o),
        .vbusy_a_o(vbusy_a_o), .vbusy_b_o(vbusy_b_o), .vbusy_c_o(vbusy_c_o),
        .vwaddr_a_i(vwaddr_a_i), .vwaddr_b_i(vwaddr_b_i),
        .vwdata_a_i(vwdata_a_i), .vwdata_b_i(vwdata_b_i),
        .vwbe_a_i(vwbe_a_i), .vwbe_b_i(vwbe_b_i),
        .vwe_a_i(vwe_a_i), .vwe_b_i(vwe_b_i),
        .vwrel_a_i(vwrel_a_i), .vwrel_b_i(vwrel_b_i),
        .vres_valid_i(vres_valid_i), .vres_addr_i(vres_addr_i),
        .vres_ready_o(vres_ready_o), .vrel_err_o(vrel_err_o)
    );

    // Reference state: registers held as byte arrays, busy flags, error pulse.
    logic [7:0] m_mem [NR][NB];
    bit         m_busy [NR];
    bit         m_err;

    int tests = 0;
    int fails = 0;

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_busy[r] = 1'b0;
            for (int n = 0; n < NB; n++) m_mem[r][n] = 8'h00;
        end
        m_err = 1'b0;
    endtask

    // Expected read value: stored bytes, overlaid by this cycle's enabled write bytes.
    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] addr);
        logic [DW-1:0] r;
        r = '0;
        if (addr == 0) return r;
        for (int n = 0; n < NB; n++) begin
            r[8*n +: 8] = m_mem[addr][n];
            if (vwe_a_i && vwaddr_a_i == addr && vwbe_a_i[n]) r[8*n +: 8] = vwdata_a_i[8*n +: 8];
            if (vwe_b_i && vwaddr_b_i == addr && vwbe_b_i[n]) r[8*n +: 8] = vwdata_b_i[8*n +: 8];
        end
        return r;
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_step();
        bit nb [NR];
        bit e;
        if (rst) begin
            model_reset();
            return;
        end
        nb = m_busy;
        e  = 1'b0;
        if (vwe_a_i && vwaddr_a_i != 0) begin
            for (int n = 0; n < NB; n++)
                if (vwbe_a_i[n]) m_mem[vwaddr_a_i][n] = vwdata_a_i[8*n +: 8];
            if (vwrel_a_i) begin
                if (!m_busy[vwaddr_a_i]) e = 1'b1;
                nb[vwaddr_a_i] = 1'b0;
            end
        end
        if (vwe_b_i && vwaddr_b_i != 0) begin
            for (int n = 0; n < NB; n++)
                if (vwbe_b_i[n]) m_mem[vwaddr_b_i][n] = vwdata_b_i[8*n +: 8];
            if (vwrel_b_i) begin
                if (!m_busy[vwaddr_b_i]) e = 1'b1;
                nb[vwaddr_b_i] = 1'b0;
            end
        end
        if (vres_valid_i && vres_addr_i != 0 && !m_busy[vres_addr_i]) nb[vres_addr_i] = 1'b1;
        m_busy = nb;
        m_err  = e;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        vwe_a_i = 1'b0; vwe_b_i = 1'b0; vwrel_a_i = 1'b0; vwrel_b_i = 1'b0;
        vwbe_a_i = '0; vwbe_b_i = '0; vwdata_a_i = '0; vwdata_b_i = '0;
        vwaddr_a_i = '0; vwaddr_b_i = '0;
        vres_valid_i = 1'b0; vres_addr_i = '0;
    endtask

    // One transaction: compare all outputs mid-cycle, then advance DUT and model.
    task automatic cycle(input string tag);
        @(negedge clk);
        check({tag, "/rd_a"}, vrdata_a_o, m_read(vraddr_a_i));
        check({tag, "/rd_b"}, vrdata_b_o, m_read(vraddr_b_i));
        check({tag, "/rd_c"}, vrdata_c_o, m_read(vraddr_c_i));
        check({tag, "/busy_a"}, DW'(vbusy_a_o), DW'(m_busy[vraddr_a_i]));
        check({tag, "/busy_b"}, DW'(vbusy_b_o), DW'(m_busy[vraddr_b_i]));
        check({tag, "/busy_c"}, DW'(vbusy_c_o), DW'(m_busy[vraddr_c_i]));
        check({tag, "/ready"}, DW'(vres_ready_o), DW'(!m_busy[vres_addr_i]));
        check({tag, "/rel_err"}, DW'(vrel_err_o), DW'(m_err));
        $display("[TB] %s rst=%0b weA=%0b@%0d relA=%0b weB=%0b@%0d relB=%0b res=%0b@%0d rdy=%0b err=%0b",
                 tag, rst, vwe_a_i, vwaddr_a_i, vwrel_a_i, vwe_b_i, vwaddr_b_i, vwrel_b_i,
                 vres_valid_i, vres_addr_i, vres_ready_o, vrel_err_o);
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [DW-1:0] exp_mix;
        idle();
        vraddr_a_i = '0; vraddr_b_i = '0; vraddr_c_i = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // 1: every register reads zero and idle after reset
        for (int i = 0; i < NR; i++) begin
            vraddr_a_i = AW'(i); vraddr_b_i = AW'(i); vraddr_c_i = AW'(i);
            #1;
            check("t1_rd_zero", vrdata_b_o, '0);
            check("t1_busy", DW'(vbusy_c_o), '0);
            cycle("t1");
        end
        check("t1_ready", DW'(vres_ready_o), DW'(1'b1));

        // 2: colliding writes, B wins the lower half
        exp_mix = {{16{8'hAA}}, {16{8'h55}}};
        idle();
        vwe_a_i = 1'b1; vwaddr_a_i = 5; vwdata_a_i = {32{8'hAA}}; vwbe_a_i = '1;
        vwe_b_i = 1'b1; vwaddr_b_i = 5; vwdata_b_i = {32{8'h55}}; vwbe_b_i = 32'h0000_FFFF;
        vraddr_a_i = 5;
        #1;
        check("t2_bypass", vrdata_a_o, exp_mix);
        cycle("t2_wr");
        idle();
        #1;
        check("t2_array", vrdata_a_o, exp_mix);
        cycle("t2_rd");

        // 3: reserve / re-reserve / release handshake on v7
        vres_valid_i = 1'b1; vres_addr_i = 7; vraddr_a_i = 7;
        #1;
        check("t3_ready1", DW'(vres_ready_o), DW'(1'b1));
        cycle("t3_res");
        #1;
        check("t3_busy", DW'(vbusy_a_o), DW'(1'b1));
        check("t3_ready0", DW'(vres_ready_o), DW'(1'b0));
        cycle("t3_res2");
        idle();
        vwe_a_i = 1'b1; vwaddr_a_i = 7; vwrel_a_i = 1'b1; vwdata_a_i = rand_data(); vwbe_a_i = '1;
        cycle("t3_rel");
        idle(); vres_addr_i = 7;
        #1;
        check("t3_busy0", DW'(vbusy_a_o), DW'(1'b0));
        check("t3_ready_again", DW'(vres_ready_o), DW'(1'b1));
        check("t3_no_err", DW'(vrel_err_o), DW'(1'b0));
        cycle("t3_post");

        // 4: releasing a register that was never reserved
        idle();
        vwe_a_i = 1'b1; vwaddr_a_i = 9; vwrel_a_i = 1'b1; vwdata_a_i = {32{8'h3C}}; vwbe_a_i = '1;
        #1;
        check("t4_err_pre", DW'(vrel_err_o), DW'(1'b0));
        cycle("t4_rel");
        idle(); vraddr_a_i = 9;
        #1;
        check("t4_err_pulse", DW'(vrel_err_o), DW'(1'b1));
        check("t4_data", vrdata_a_o, {32{8'h3C}});
        cycle("t4_pulse");
        #1;
        check("t4_err_gone", DW'(vrel_err_o), DW'(1'b0));
        cycle("t4_after");

        // 5: v0 ignores writes, reserves and releases
        idle();
        vwe_a_i = 1'b1; vwaddr_a_i = 0; vwrel_a_i = 1'b1; vwdata_a_i = {32{8'hFF}}; vwbe_a_i = '1;
        vres_valid_i = 1'b1; vres_addr_i = 0; vraddr_a_i = 0;
        #1;
        check("t5_rd_same", vrdata_a_o, '0);
        check("t5_ready", DW'(vres_ready_o), DW'(1'b1));
        cycle("t5_wr");
        idle();
        #1;
        check("t5_rd", vrdata_a_o, '0);
        check("t5_busy", DW'(vbusy_a_o), DW'(1'b0));
        check("t5_err", DW'(vrel_err_o), DW'(1'b0));
        cycle("t5_post");

        // 6: reset in the middle of an operation on v3
        idle(); vres_valid_i = 1'b1; vres_addr_i = 3;
        cycle("t6_res");
        idle(); vwe_a_i = 1'b1; vwaddr_a_i = 3; vwdata_a_i = {32{8'h12}}; vwbe_a_i = '1;
        cycle("t6_wr");
        idle(); rst = 1'b1;
        cycle("t6_rst");
        idle(); vraddr_a_i = 3; vres_addr_i = 3;
        #1;
        check("t6_rd", vrdata_a_o, '0);
        check("t6_busy", DW'(vbusy_a_o), DW'(1'b0));
        check("t6_err", DW'(vrel_err_o), DW'(1'b0));
        check("t6_ready", DW'(vres_ready_o), DW'(1'b1));
        cycle("t6_post");

        // Random traffic on a small address window to force collisions
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            vwe_a_i      = !rst && $urandom_range(0, 1);
            vwe_b_i      = !rst && $urandom_range(0, 1);
            vwrel_a_i    = ($urandom_range(0, 3) == 0);
            vwrel_b_i    = ($urandom_range(0, 3) == 0);
            vwaddr_a_i   = rand_addr();
            vwaddr_b_i   = ($urandom_range(0, 3) == 0) ? vwaddr_a_i : rand_addr();
            vwdata_a_i   = rand_data();
            vwdata_b_i   = rand_data();
            vwbe_a_i     = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom());
            vwbe_b_i     = NB'($urandom());
            vres_valid_i = $urandom_range(0, 1);
            vres_addr_i  = rand_addr();
            vraddr_a_i   = ($urandom_range(0, 1) == 1) ? vwaddr_a_i : rand_addr();
            vraddr_b_i   = ($urandom_range(0, 1) == 1) ? vwaddr_b_i : rand_addr();
            vraddr_c_i   = rand_addr();
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
